// File: rtl/seg7_if.sv
// Multiplexed 7-segment pin bundle plus the decoded-report handshake.
interface seg7_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned DIGIT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [7:0]         seg_in;
    logic [DIGITS-1:0]  an_in;
    logic               out_valid;
    logic               out_ready;
    logic [DIGIT_W-1:0] out_digit;
    logic [3:0]         out_value;
    logic               out_dp;
    logic               out_err;

    // Reader side: samples the pins and produces reports.
    modport master (
        input  seg_in, an_in, out_ready,
        output out_valid, out_digit, out_value, out_dp, out_err
    );

    // Display/consumer side: drives the pins and accepts reports.
    modport slave (
        output seg_in, an_in, out_ready,
        input  out_valid, out_digit, out_value, out_dp, out_err
    );
endinterface

// File: rtl/seg7_reader.sv
// Recovers hex digits from a multiplexed 7-segment bus and reports each change once.
module seg7_reader #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic   clk,
    input  logic   rst,
    seg7_if.master bus
);
    localparam int unsigned DIGIT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SAMPLE_W = DIGITS + 8;

    typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

    logic [SAMPLE_W-1:0] sync1, sync2, held;
    logic [CNT_W-1:0]    count;
    state_t              state;
    logic [7:0]          shadow [DIGITS];
    logic [DIGITS-1:0]   shadow_full;

    logic [DIGITS-1:0]   held_an_c;
    logic [7:0]          held_seg_c;
    logic                held_onehot_c;
    logic [DIGIT_W-1:0]  held_idx_c;
    logic [3:0]          dec_value_c;
    logic                dec_err_c;
    logic                stable_c;
    logic                is_new_c;
    logic                handshake_c;

    assign held_an_c     = held[SAMPLE_W-1:8];
    assign held_seg_c    = held[7:0];
    assign held_onehot_c = $onehot(held_an_c);
    assign stable_c      = (count == CNT_W'(STABLE_CYCLES));
    assign handshake_c   = bus.out_valid && bus.out_ready;
    assign is_new_c      = !shadow_full[held_idx_c] || (shadow[held_idx_c] != held_seg_c);

    // One-hot anode to digit index (only meaningful when exactly one bit is set).
    always_comb begin
        held_idx_c = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (held_an_c[i]) held_idx_c = DIGIT_W'(i);
        end
    end

    // Inverse segment map; anything outside the hex font is flagged as an error.
    always_comb begin
        dec_value_c = 4'h0;
        dec_err_c   = 1'b0;
        case (held_seg_c[6:0])
            7'h3F: dec_value_c = 4'h0;
            7'h06: dec_value_c = 4'h1;
            7'h5B: dec_value_c = 4'h2;
            7'h4F: dec_value_c = 4'h3;
            7'h66: dec_value_c = 4'h4;
            7'h6D: dec_value_c = 4'h5;
            7'h7D: dec_value_c = 4'h6;
            7'h07: dec_value_c = 4'h7;
            7'h7F: dec_value_c = 4'h8;
            7'h6F: dec_value_c = 4'h9;
            7'h77: dec_value_c = 4'hA;
            7'h7C: dec_value_c = 4'hB;
            7'h39: dec_value_c = 4'hC;
            7'h5E: dec_value_c = 4'hD;
            7'h79: dec_value_c = 4'hE;
            7'h71: dec_value_c = 4'hF;
            default: dec_err_c = 1'b1;
        endcase
    end

    // Pin synchroniser, held sample and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            held  <= '0;
            count <= '0;
        end else begin
            sync1 <= {bus.an_in, bus.seg_in};
            sync2 <= sync1;
            if (sync2 != held) held <= sync2;
            if (handshake_c)            count <= '0;
            else if (sync2 != held)     count <= CNT_W'(1);
            else if (!stable_c)         count <= count + CNT_W'(1);
        end
    end

    // Report FSM: qualifies a stable, changed pattern and holds it until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_digit <= '0;
            bus.out_value <= 4'h0;
            bus.out_dp    <= 1'b0;
            bus.out_err   <= 1'b0;
            shadow_full   <= '0;
            for (int unsigned i = 0; i < DIGITS; i++) shadow[i] <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (held_onehot_c) state <= SETTLE;
                end
                SETTLE: begin
                    if (!held_onehot_c) begin
                        state <= IDLE;
                    end else if (stable_c && is_new_c) begin
                        bus.out_valid           <= 1'b1;
                        bus.out_digit           <= held_idx_c;
                        bus.out_value           <= dec_value_c;
                        bus.out_dp              <= held_seg_c[7];
                        bus.out_err             <= dec_err_c;
                        shadow[held_idx_c]      <= held_seg_c;
                        shadow_full[held_idx_c] <= 1'b1;
                        state                   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (handshake_c) begin
                        bus.out_valid <= 1'b0;
                        state         <= held_onehot_c ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with hand-computed expected reports.
module tb_seg7_reader;
    localparam int unsigned DIGITS        = 4;
    localparam int unsigned STABLE_CYCLES = 8;

    logic clk = 1'b0;
    logic rst;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned rpt_cnt     = 0;
    int unsigned rpt0;

    logic [7:0] font [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    seg7_if #(.DIGITS(DIGITS)) bus ();

    seg7_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Count accepted reports.
    always @(posedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) rpt_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < max_cyc) begin
            step(1);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic expect_report(input string tag, input int digit, input int value,
                                 input bit dp, input bit err);
        chk({tag, "_digit"}, 32'(bus.out_digit), 32'(digit));
        chk({tag, "_value"}, 32'(bus.out_value), 32'(value));
        chk({tag, "_dp"},    32'(bus.out_dp),    32'(dp));
        chk({tag, "_err"},   32'(bus.out_err),   32'(err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // 1: reset values, exact latency, no duplicate report
        rst = 1'b1;
        bus.an_in = 4'b0001;
        bus.seg_in = 8'h3F;
        bus.out_ready = 1'b1;
        step(3);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        expect_report("rst", 0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        step(10);
        chk("t1_early", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        expect_report("t1", 0, 0, 1'b0, 1'b0);
        step(9);
        chk("t1_single", 32'(rpt_cnt), 32'd1);
        chk("t1_idle", 32'(bus.out_valid), 32'd0);

        // 2: short-lived pattern is filtered
        rpt0 = rpt_cnt;
        bus.an_in = 4'b0010;
        bus.seg_in = 8'h3F;
        step(5);
        bus.seg_in = 8'h06;
        wait_valid("t2", 40);
        chk("t2_noglitch", 32'(rpt_cnt), 32'(rpt0));
        expect_report("t2", 1, 1, 1'b0, 1'b0);
        step(2);

        // 3: change while presenting is held back then reported after the handshake
        bus.out_ready = 1'b0;
        bus.an_in = 4'b0100;
        bus.seg_in = 8'h4F;
        wait_valid("t3a", 40);
        expect_report("t3a", 2, 3, 1'b0, 1'b0);
        bus.seg_in = 8'h66;
        step(20);
        chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
        expect_report("t3_hold", 2, 3, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        chk("t3_drop", 32'(bus.out_valid), 32'd0);
        step(STABLE_CYCLES);
        chk("t3_early", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("t3b_valid", 32'(bus.out_valid), 32'd1);
        expect_report("t3b", 2, 4, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step(2);

        // 4: two-hot anodes never produce a report
        rpt0 = rpt_cnt;
        bus.an_in = 4'b0011;
        bus.seg_in = 8'h7F;
        step(30);
        chk("t4_count", 32'(rpt_cnt), 32'(rpt0));
        chk("t4_valid", 32'(bus.out_valid), 32'd0);

        // 5: bad pattern flagged; dp toggle alone is a change
        bus.an_in = 4'b1000;
        bus.seg_in = 8'h49;
        wait_valid("t5a", 40);
        expect_report("t5a", 3, 0, 1'b0, 1'b1);
        step(2);
        bus.seg_in = 8'hC9;
        wait_valid("t5b", 40);
        expect_report("t5b", 3, 0, 1'b1, 1'b1);
        step(2);

        // 6: reset drops a pending report, which is re-reported after release
        bus.out_ready = 1'b0;
        bus.seg_in = 8'h06;
        wait_valid("t6a", 40);
        expect_report("t6a", 3, 1, 1'b0, 1'b0);
        rst = 1'b1;
        step(1);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_digit", 32'(bus.out_digit), 32'd0);
        step(2);
        rst = 1'b0;
        step(10);
        chk("t6_early", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("t6b_valid", 32'(bus.out_valid), 32'd1);
        expect_report("t6b", 3, 1, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step(2);

        // Full font sweep on digit 0
        bus.an_in = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            bus.seg_in = font[i];
            wait_valid($sformatf("font%0d", i), 40);
            chk($sformatf("font%0d_value", i), 32'(bus.out_value), 32'(i));
            chk($sformatf("font%0d_err", i), 32'(bus.out_err), 32'd0);
            step(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
